// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the alu_nbit datapath ALU.
//   - opcode width and opcode enum (ALU_AND .. ALU_RSVD)
//   - controller state enum (ST_IDLE, ST_BUSY, ST_DONE)
package alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    ALU_AND  = 3'b000,
    ALU_OR   = 3'b001,
    ALU_ADD  = 3'b010,
    ALU_SUB  = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_NOR  = 3'b101,
    ALU_MUL  = 3'b110,
    ALU_RSVD = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_addsub.sv
// alu_addsub: combinational WIDTH-bit adder/subtractor shared by ADD, SUB, SLT.
// Ports:
//   a, b  in   operands (two's complement)
//   sub   in   1 = a + ~b + 1, 0 = a + b
//   sum   out  low WIDTH bits of the result
//   cout  out  carry-out of bit WIDTH-1 (for subtract: 1 = no borrow)
//   ovf   out  signed overflow
module alu_addsub #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;

  assign b_eff        = sub ? ~b : b;
  assign {cout, sum}  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  // Overflow is judged against the effective (possibly inverted) second operand.
  assign ovf          = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_nbit.sv
// alu_nbit: N-bit integer ALU with a registered valid/ready result interface.
// Optional iterative shift-add multiplier, enabled by macro ALU_MUL_EN.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  request handshake (in_ready = IDLE)
//   op, a, b             opcode and operands, captured on acceptance
//   out_valid/out_ready  result handshake (out_valid = DONE)
//   result, result_hi    low word / high product word (0 unless MUL)
//   zero, carry, overflow, illegal  status flags, registered with result
//
// state   | meaning
// IDLE    | waiting for a request
// BUSY    | multiplier iterating, one shift-add step per cycle
// DONE    | result presented, held until out_ready
module alu_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  alu_state_e       state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, carry_q, overflow_q, illegal_q;

  logic [WIDTH-1:0] result_d;
  logic             carry_d, overflow_d, illegal_d;

  logic [WIDTH-1:0] as_sum;
  logic             as_cout, as_ovf, as_sub;

  assign as_sub = (op == ALU_SUB) || (op == ALU_SLT);

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .b    (b),
    .sub  (as_sub),
    .sum  (as_sum),
    .cout (as_cout),
    .ovf  (as_ovf)
  );

  // Single-cycle result, computed from the live operands in the accepting cycle.
  always_comb begin
    result_d   = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    illegal_d  = 1'b0;
    case (op)
      ALU_AND: result_d = a & b;
      ALU_OR:  result_d = a | b;
      ALU_NOR: result_d = ~(a | b);
      ALU_ADD, ALU_SUB: begin
        result_d   = as_sum;
        carry_d    = as_cout;
        overflow_d = as_ovf;
      end
      ALU_SLT: result_d = {{(WIDTH-1){1'b0}}, as_sum[WIDTH-1] ^ as_ovf};
      default: illegal_d = 1'b1;  // reserved, and MUL when the multiplier is absent
    endcase
  end

`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] result_hi_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] step_hi, step_lo;

  // {result_hi_q, result_q} is the product register; the multiplier starts in
  // the low half and is shifted out as partial products shift in from the top.
  always_comb begin
    step_sum = {1'b0, result_hi_q} + (result_q[0] ? {1'b0, mcand_q} : '0);
    step_hi  = step_sum[WIDTH:1];
    step_lo  = {step_sum[0], result_q[WIDTH-1:1]};
  end

  assign result_hi = result_hi_q;
`else
  assign result_hi = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      result_q   <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef ALU_MUL_EN
      mcand_q     <= '0;
      result_hi_q <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
`ifdef ALU_MUL_EN
            if (op == ALU_MUL) begin
              mcand_q     <= a;
              result_q    <= b;
              result_hi_q <= '0;
              zero_q      <= 1'b0;
              carry_q     <= 1'b0;
              overflow_q  <= 1'b0;
              illegal_q   <= 1'b0;
              cnt_q       <= CW'(WIDTH);
              state_q     <= ST_BUSY;
            end else begin
              result_hi_q <= '0;
`else
            begin
`endif
              result_q   <= result_d;
              zero_q     <= (result_d == '0);
              carry_q    <= carry_d;
              overflow_q <= overflow_d;
              illegal_q  <= illegal_d;
              state_q    <= ST_DONE;
            end
          end
        end
`ifdef ALU_MUL_EN
        ST_BUSY: begin
          result_hi_q <= step_hi;
          result_q    <= step_lo;
          cnt_q       <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            zero_q  <= (step_lo == '0);
            state_q <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_nbit.sv
// tb_alu_nbit: table-driven check of alu_nbit at WIDTH=8, plus reset-mid-op
// and backpressure sequences. MUL expectations follow ALU_MUL_EN.
module tb_alu_nbit;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'b000;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result, result_hi;
  logic         zero, carry, overflow, illegal;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_nbit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_hi(result_hi), .zero(zero), .carry(carry),
    .overflow(overflow), .illegal(illegal)
  );

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] res, res_hi;
    logic         z, c, v, ill;
    int           lat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                              input logic [W-1:0] r, input logic [W-1:0] rh,
                              input logic z, input logic c, input logic v, input logic il,
                              input int lat);
    vec_t t;
    t.op = o; t.a = av; t.b = bv; t.res = r; t.res_hi = rh;
    t.z = z; t.c = c; t.v = v; t.ill = il; t.lat = lat;
    return t;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    @(negedge clk);
    chk($sformatf("v%0d_in_ready_pre", idx), {15'b0, in_ready}, 16'd1);
    op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble operands after acceptance; the result must not depend on them.
    in_valid = 1'b0; a = ~v.a; b = ~v.b; op = 3'b010;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("v%0d_latency", idx), 16'(lat), 16'(v.lat));
    chk($sformatf("v%0d_result", idx), {8'b0, result}, {8'b0, v.res});
    chk($sformatf("v%0d_result_hi", idx), {8'b0, result_hi}, {8'b0, v.res_hi});
    chk($sformatf("v%0d_flags_zcvi", idx), {12'b0, zero, carry, overflow, illegal},
        {12'b0, v.z, v.c, v.v, v.ill});
    @(posedge clk); #1;
    chk($sformatf("v%0d_in_ready_post", idx), {15'b0, in_ready}, 16'd1);
    chk($sformatf("v%0d_out_valid_post", idx), {15'b0, out_valid}, 16'd0);
  endtask

  initial begin
    //        op      a      b      res    hi     z     c     v     ill   lat
    vecs.push_back(mk(3'b010, 8'h7F, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1));
    vecs.push_back(mk(3'b010, 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b011, 8'h05, 8'h05, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b011, 8'h03, 8'h05, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b011, 8'h80, 8'h01, 8'h7F, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1));
    vecs.push_back(mk(3'b100, 8'h80, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b100, 8'h01, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b100, 8'h03, 8'h05, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b000, 8'hF0, 8'h3C, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b001, 8'h0F, 8'hF0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b101, 8'h0F, 8'hF0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b101, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(3'b111, 8'h12, 8'h34, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1));
`ifdef ALU_MUL_EN
    vecs.push_back(mk(3'b110, 8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 9));
    vecs.push_back(mk(3'b110, 8'h0F, 8'h11, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 9));
    vecs.push_back(mk(3'b110, 8'h00, 8'h55, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 9));
    vecs.push_back(mk(3'b110, 8'h10, 8'h10, 8'h00, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 9));
`else
    vecs.push_back(mk(3'b110, 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1));
`endif

    // Reset state.
    #12;
    chk("rst_in_ready", {15'b0, in_ready}, 16'd1);
    chk("rst_out_valid", {15'b0, out_valid}, 16'd0);
    chk("rst_outputs", {result, result_hi}, 16'h0000);
    chk("rst_flags", {12'b0, zero, carry, overflow, illegal}, 16'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

    // Reset in the middle of a MUL.
    @(negedge clk);
    op = 3'b110; a = 8'h0F; b = 8'h11; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {15'b0, out_valid}, 16'd0);
    chk("midrst_outputs", {result, result_hi}, 16'h0000);
    chk("midrst_flags", {12'b0, zero, carry, overflow, illegal}, 16'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", {15'b0, in_ready}, 16'd1);
    @(posedge clk); #1;
    chk("midrst_no_result", {15'b0, out_valid}, 16'd0);

    // Backpressure: AND result held while out_ready is low, new request ignored.
    out_ready = 1'b0;
    @(negedge clk);
    op = 3'b000; a = 8'hF0; b = 8'h3C; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        op = 3'b010; a = 8'h01; b = 8'h01; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk($sformatf("bp%0d_out_valid", c), {15'b0, out_valid}, 16'd1);
      chk($sformatf("bp%0d_result", c), {8'b0, result}, 16'h0030);
      chk($sformatf("bp%0d_in_ready", c), {15'b0, in_ready}, 16'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_hold_result", {8'b0, result}, 16'h0030);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {15'b0, in_ready}, 16'd1);
    chk("bp_release_out_valid", {15'b0, out_valid}, 16'd0);
    @(posedge clk); #1;
    chk("bp_not_queued", {15'b0, out_valid}, 16'd0);
    chk("bp_result_kept", {8'b0, result}, 16'h0030);

    // Back-to-back after backpressure: plain ADD still works.
    run_vec(mk(3'b010, 8'h11, 8'h22, 8'h33, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1), 99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
